// File: rtl/axil_master_pkg.sv
// Shared constants for the AXI4-Lite command master: FSM encoding, AXI response codes and
// the watchdog limit used when AXIL_MASTER_TIMEOUT_EN is defined.
package axil_master_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

  // States in which the master is waiting on the slave.
  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_WR) || (st == ST_WR_RESP) || (st == ST_RD_ADDR) || (st == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axil_lite_master_if.sv
// AXI4-Lite bus bundle between the command master and a slave; master drives AW/W/AR and
// the B/R readies, slave drives the rest.
interface axil_lite_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite master: one cmd -> one AXI write/read -> one rsp; 3 cycles cmd->rsp on a zero-wait slave.
// cmd_ready only in IDLE, rsp held until rsp_ready; optional watchdog via AXIL_MASTER_TIMEOUT_EN (adds timeout_flag).
module axil_lite_master
  import axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axil_lite_master_if.master      m_axi
`ifdef AXIL_MASTER_TIMEOUT_EN
  ,
  output logic                    timeout_flag
`endif
);

  logic [2:0] state;
  logic       aw_done;
  logic       w_done;
  logic       aw_fin;
  logic       w_fin;
  logic       advance;

  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;

  // advance marks the edge at which the current busy state hands off to the next one.
  always_comb begin
    aw_fin  = aw_done | (m_axi.awvalid & m_axi.awready);
    w_fin   = w_done  | (m_axi.wvalid  & m_axi.wready);
    advance = 1'b0;
    case (state)
      ST_WR:      advance = aw_fin & w_fin;
      ST_WR_RESP: advance = m_axi.bready & m_axi.bvalid;
      ST_RD_ADDR: advance = m_axi.arvalid & m_axi.arready;
      ST_RD_DATA: advance = m_axi.rready & m_axi.rvalid;
      default:    advance = 1'b0;
    endcase
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic [15:0] wdog;
  logic        wdog_hit;

  assign wdog_hit = is_busy(state) && !advance && (wdog == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst || !is_busy(state) || advance || wdog_hit) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wstrb   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      timeout_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi.awaddr  <= cmd_addr;
              m_axi.wdata   <= cmd_wdata;
              m_axi.wstrb   <= cmd_wstrb;
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= ST_WR;
            end else begin
              m_axi.araddr  <= cmd_addr;
              m_axi.arvalid <= 1'b1;
              state         <= ST_RD_ADDR;
            end
          end
        end
        ST_WR: begin
          // AW and W retire independently; the payload registers are untouched until then.
          if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
          aw_done <= aw_fin;
          w_done  <= w_fin;
          if (advance) begin
            m_axi.bready <= 1'b1;
            state        <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (advance) begin
            m_axi.bready <= 1'b0;
            rsp_resp     <= m_axi.bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            state        <= ST_RSP;
          end
        end
        ST_RD_ADDR: begin
          if (advance) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (advance) begin
            m_axi.rready <= 1'b0;
            rsp_rdata    <= m_axi.rdata;
            rsp_resp     <= m_axi.rresp;
            rsp_valid    <= 1'b1;
            state        <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
      // A stalled slave is abandoned and the host sees a synthetic SLVERR.
      if (wdog_hit) begin
        m_axi.awvalid <= 1'b0;
        m_axi.wvalid  <= 1'b0;
        m_axi.bready  <= 1'b0;
        m_axi.arvalid <= 1'b0;
        m_axi.rready  <= 1'b0;
        rsp_resp      <= RESP_SLVERR;
        rsp_rdata     <= '0;
        rsp_valid     <= 1'b1;
        timeout_flag  <= 1'b1;
        state         <= ST_RSP;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axil_lite_master.sv
// Directed bench for axil_lite_master with a behavioural AXI4-Lite slave (ready delays, error injection).
// Define AXIL_MASTER_TIMEOUT_EN for both DUT and bench to exercise the watchdog case.
module tb_axil_lite_master;
  import axil_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef AXIL_MASTER_TIMEOUT_EN
  logic        timeout_flag;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axil_lite_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

  axil_lite_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi(axi)
`ifdef AXIL_MASTER_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  // Behavioural slave: 128-word register file, programmable AW delay, stuck AR, error on 0x0000.
  logic [31:0] mem [0:127];
  int          aw_cnt;
  int          aw_delay = 0;
  bit          ar_stuck = 1'b0;
  bit          err_mode = 1'b0;
  logic        have_aw, have_w;
  logic [15:0] s_awaddr;
  logic [31:0] s_wdata;

  wire aw_hs = axi.awvalid && axi.awready;
  wire w_hs  = axi.wvalid && axi.wready;
  wire ar_hs = axi.arvalid && axi.arready;
  wire [15:0] wr_addr = aw_hs ? axi.awaddr : s_awaddr;
  wire [31:0] wr_data = w_hs ? axi.wdata : s_wdata;

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
  assign axi.wready  = axi.wvalid;
  assign axi.arready = axi.arvalid && !ar_stuck;

  initial for (int i = 0; i < 128; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt     <= 0;
      have_aw    <= 1'b0;
      have_w     <= 1'b0;
      s_awaddr   <= '0;
      s_wdata    <= '0;
      axi.bvalid <= 1'b0;
      axi.bresp  <= RESP_OKAY;
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
      axi.rresp  <= RESP_OKAY;
    end else begin
      if (axi.awvalid && !axi.awready) aw_cnt <= aw_cnt + 1;
      else if (aw_hs) aw_cnt <= 0;
      if (aw_hs) begin have_aw <= 1'b1; s_awaddr <= axi.awaddr; end
      if (w_hs)  begin have_w  <= 1'b1; s_wdata  <= axi.wdata;  end
      if ((have_aw || aw_hs) && (have_w || w_hs)) begin
        mem[wr_addr[8:2]] <= wr_data;
        axi.bvalid <= 1'b1;
        axi.bresp  <= RESP_OKAY;
        have_aw    <= 1'b0;
        have_w     <= 1'b0;
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (ar_hs) begin
        axi.rvalid <= 1'b1;
        if (err_mode && axi.araddr == 16'h0000) begin
          axi.rdata <= 32'hFFFF_FFFF;
          axi.rresp <= RESP_SLVERR;
        end else begin
          axi.rdata <= mem[axi.araddr[8:2]];
          axi.rresp <= RESP_OKAY;
        end
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one command and returns #1 after the accepting edge.
  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // lat counts negedges after the accepting edge until rsp_valid is seen.
  task automatic wait_rsp(input int limit, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < limit);
    chk("rsp_arrives", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] expv;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_valids", {29'd0, axi.awvalid, axi.wvalid, axi.arvalid}, 32'd0);
    chk("rst_readies", {30'd0, axi.bready, axi.rready}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    chk("rst_addr_regs", {axi.awaddr, axi.araddr}, 32'd0);
    chk("rst_wdata", axi.wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Zero-wait write, cycle by cycle
    send_cmd(1'b1, 16'h0008, 32'h0003_0001, 4'hF);
    @(negedge clk);
    chk("w0_n1_aw_w_valid", {30'd0, axi.awvalid, axi.wvalid}, 32'd3);
    chk("w0_n1_awaddr", {16'd0, axi.awaddr}, 32'h0008);
    chk("w0_n1_wdata", axi.wdata, 32'h0003_0001);
    chk("w0_n1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("w0_n2_valids_low", {30'd0, axi.awvalid, axi.wvalid}, 32'd0);
    chk("w0_n2_bready", {31'd0, axi.bready}, 32'd1);
    chk("w0_n2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("w0_n3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("w0_n3_resp", {30'd0, rsp_resp}, 32'd0);
    chk("w0_n3_rdata", rsp_rdata, 32'd0);
    take_rsp();
    @(negedge clk);
    chk("w0_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("w0_slave_reg", mem[2], 32'h0003_0001);

    // AW stalled 3 cycles, W immediate
    aw_delay = 3;
    send_cmd(1'b1, 16'h000C, 32'h1234_5678, 4'hF);
    @(negedge clk);
    chk("w1_n1_aw_w_valid", {30'd0, axi.awvalid, axi.wvalid}, 32'd3);
    @(negedge clk);
    chk("w1_n2_wvalid_aw_hold", {30'd0, axi.awvalid, axi.wvalid}, 32'd2);
    chk("w1_n2_awaddr_stable", {16'd0, axi.awaddr}, 32'h000C);
    @(negedge clk);
    chk("w1_n3_awvalid", {31'd0, axi.awvalid}, 32'd1);
    @(negedge clk);
    chk("w1_n4_awvalid", {30'd0, axi.awvalid, axi.bready}, 32'd2);
    @(negedge clk);
    chk("w1_n5_aw_low_bready", {30'd0, axi.awvalid, axi.bready}, 32'd1);
    wait_rsp(20, lat);
    chk("w1_resp", {30'd0, rsp_resp}, 32'd0);
    take_rsp();
    chk("w1_slave_reg", mem[3], 32'h1234_5678);
    aw_delay = 0;

    // Block write then read back, one command in flight at a time
    for (int i = 0; i < 25; i++) begin
      send_cmd(1'b1, 16'h0100 + 16'(4 * i), 32'(i + 1), 4'hF);
      wait_rsp(20, lat);
      chk($sformatf("blk_wr%0d_resp", i), {30'd0, rsp_resp}, 32'd0);
      take_rsp();
    end
    for (int i = 0; i < 25; i++) begin
      send_cmd(1'b0, 16'h0100 + 16'(4 * i), 32'd0, 4'h0);
      wait_rsp(20, lat);
      if (i == 0) chk("rd_latency", 32'(lat), 32'd3);
      expv = 32'(i + 1);
      chk($sformatf("blk_rd%0d_data", i), rsp_rdata, expv);
      chk($sformatf("blk_rd%0d_resp", i), {30'd0, rsp_resp}, 32'd0);
      chk($sformatf("blk_rd%0d_busy", i), {31'd0, cmd_ready}, 32'd0);
      take_rsp();
    end

    // SLVERR passthrough with host backpressure on rsp
    err_mode = 1'b1;
    send_cmd(1'b0, 16'h0000, 32'd0, 4'h0);
    wait_rsp(20, lat);
    chk("err_resp", {30'd0, rsp_resp}, 32'd2);
    chk("err_rdata", rsp_rdata, 32'hFFFF_FFFF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("err_hold%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("err_hold%0d_data", k), rsp_rdata, 32'hFFFF_FFFF);
      chk($sformatf("err_hold%0d_resp", k), {30'd0, rsp_resp}, 32'd2);
      chk($sformatf("err_hold%0d_cmd_ready", k), {31'd0, cmd_ready}, 32'd0);
    end
    take_rsp();
    err_mode = 1'b0;

    // Reset one cycle after awvalid rises
    aw_delay = 5;
    send_cmd(1'b1, 16'h01F0, 32'h0000_DEAD, 4'hF);
    @(negedge clk);
    chk("mid_rst_awvalid_up", {31'd0, axi.awvalid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valids", {29'd0, axi.awvalid, axi.wvalid, axi.arvalid}, 32'd0);
    chk("mid_rst_ready_outs", {28'd0, axi.bready, axi.rready, cmd_ready, rsp_valid}, 32'd0);
    rst = 1'b0;
    chk("mid_rst_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("mid_rst_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rst_no_write", mem[124], 32'd0);
    aw_delay = 0;
    send_cmd(1'b1, 16'h0004, 32'h0000_55AA, 4'hF);
    wait_rsp(20, lat);
    chk("recover_wr_resp", {30'd0, rsp_resp}, 32'd0);
    take_rsp();
    send_cmd(1'b0, 16'h0004, 32'd0, 4'h0);
    wait_rsp(20, lat);
    chk("recover_rd_data", rsp_rdata, 32'h0000_55AA);
    take_rsp();

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Stuck AR channel trips the watchdog
    chk("to_flag_clear", {31'd0, timeout_flag}, 32'd0);
    ar_stuck = 1'b1;
    send_cmd(1'b0, 16'h0100, 32'd0, 4'h0);
    wait_rsp(70000, lat);
    chk("to_latency", 32'(lat), 32'd65537);
    chk("to_resp", {30'd0, rsp_resp}, 32'd2);
    chk("to_rdata", rsp_rdata, 32'd0);
    chk("to_flag", {31'd0, timeout_flag}, 32'd1);
    chk("to_arvalid_dropped", {31'd0, axi.arvalid}, 32'd0);
    take_rsp();
    ar_stuck = 1'b0;
    send_cmd(1'b0, 16'h0100, 32'd0, 4'h0);
    wait_rsp(20, lat);
    chk("to_next_rdata", rsp_rdata, 32'd1);
    chk("to_next_resp", {30'd0, rsp_resp}, 32'd0);
    chk("to_flag_sticky", {31'd0, timeout_flag}, 32'd1);
    take_rsp();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
